// File: rtl/omsp_sha512_arbiter.sv
`default_nettype none
// ============================================================================
// omsp_sha512_arbiter - grants whole hashing sessions on one shared SHA-512
// frontend to two requesters, with a drain gap between sessions.
// Optional owner-idle preemption: define SHA512_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module omsp_sha512_arbiter #(
    parameter int PRIO_FIXED = 0,
    parameter int DRAIN_MIN  = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  cmd0,
    input  logic [1:0]  cmd1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic        size0,
    input  logic        size1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rdy0,
    output logic        rdy1,
    output logic        busy0,
    output logic        busy1,
    output logic [15:0] hash,
    output logic        tout,
    output logic [1:0]  fe_cmd,
    output logic [15:0] fe_data,
    output logic        fe_size,
    input  logic [15:0] fe_hash,
    input  logic        fe_busy,
    input  logic        fe_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MIN - 1);

    state_t     state_q;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       prio_q;       // port that wins the next tie in round-robin mode
    logic [3:0] drain_cnt_q;

    logic [1:0] blocked;
    logic       tmo_hit;
    logic [1:0] elig;
    logic       win;

`ifdef SHA512_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] idle_cnt_q;
    logic [1:0]  blk_q;
    logic        own_idle;

    always_comb begin
        own_idle = 1'b0;
        if (state_q == ST_OWN0) begin
            own_idle = (cmd0 == 2'b00) && !fe_busy;
        end else if (state_q == ST_OWN1) begin
            own_idle = (cmd1 == 2'b00) && !fe_busy;
        end
    end

    assign tmo_hit = own_idle && (idle_cnt_q == TIMEOUT_LAST);

    // A preempted port stays locked out until its req is sampled low once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
            blk_q      <= '0;
        end else begin
            if (own_idle && !tmo_hit) begin
                idle_cnt_q <= idle_cnt_q + 16'd1;
            end else begin
                idle_cnt_q <= '0;
            end
            blk_q[0] <= req0 & (blk_q[0] | (tmo_hit & (state_q == ST_OWN0)));
            blk_q[1] <= req1 & (blk_q[1] | (tmo_hit & (state_q == ST_OWN1)));
        end
    end

    assign blocked = blk_q;
    assign tout    = |blk_q;
`else
    logic unused_timeout;
    assign unused_timeout = |16'(TIMEOUT);
    assign blocked        = 2'b00;
    assign tmo_hit        = 1'b0;
    assign tout           = 1'b0;
`endif

    assign elig = {req1 & ~blocked[1], req0 & ~blocked[0]};

    always_comb begin
        if (elig == 2'b11) begin
            win = (PRIO_FIXED != 0) ? 1'b0 : prio_q;
        end else begin
            win = elig[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            prio_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|elig) begin
                        state_q <= win ? ST_OWN1 : ST_OWN0;
                        gnt0_q  <= ~win;
                        gnt1_q  <= win;
                        prio_q  <= ~win;
                    end
                end
                ST_OWN0: begin
                    if (!req0 || tmo_hit) begin
                        state_q     <= ST_DRAIN;
                        gnt0_q      <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                ST_OWN1: begin
                    if (!req1 || tmo_hit) begin
                        state_q     <= ST_DRAIN;
                        gnt1_q      <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                default: begin
                    // Hand over only once the frontend has gone quiet.
                    if ((drain_cnt_q >= DRAIN_LAST) && !fe_busy) begin
                        if (|elig) begin
                            state_q <= win ? ST_OWN1 : ST_OWN0;
                            gnt0_q  <= ~win;
                            gnt1_q  <= win;
                            prio_q  <= ~win;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (drain_cnt_q != 4'hF) begin
                        drain_cnt_q <= drain_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        fe_cmd  = 2'b00;
        fe_data = 16'h0000;
        fe_size = 1'b0;
        if (state_q == ST_OWN0) begin
            fe_cmd  = cmd0;
            fe_data = data0;
            fe_size = size0;
        end else if (state_q == ST_OWN1) begin
            fe_cmd  = cmd1;
            fe_data = data1;
            fe_size = size1;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign rdy0  = gnt0_q & fe_ready;
    assign rdy1  = gnt1_q & fe_ready;
    assign busy0 = (req0 & ~gnt0_q) | (gnt0_q & fe_busy);
    assign busy1 = (req1 & ~gnt1_q) | (gnt1_q & fe_busy);
    assign hash  = fe_hash;

endmodule
`default_nettype wire

// File: tb/tb_omsp_sha512_arbiter.sv
`default_nettype none
// Bench for omsp_sha512_arbiter: a round-robin (DRAIN_MIN=2) and a fixed-priority
// (DRAIN_MIN=3) instance share random stimulus and are checked against a session-level model.
module tb_omsp_sha512_arbiter;

    localparam int TO = 8;
`ifdef SHA512_ARB_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0, req1, size0, size1, fe_busy, fe_ready;
    logic [1:0]  cmd0, cmd1;
    logic [15:0] data0, data1, fe_hash;

    logic        gnt0_o [2];
    logic        gnt1_o [2];
    logic        rdy0_o [2];
    logic        rdy1_o [2];
    logic        busy0_o [2];
    logic        busy1_o [2];
    logic        tout_o [2];
    logic        fe_size_o [2];
    logic [1:0]  fe_cmd_o [2];
    logic [15:0] fe_data_o [2];
    logic [15:0] hash_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        omsp_sha512_arbiter #(
            .PRIO_FIXED (g),
            .DRAIN_MIN  (g + 2),
            .TIMEOUT    (TO)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req0     (req0),
            .req1     (req1),
            .cmd0     (cmd0),
            .cmd1     (cmd1),
            .data0    (data0),
            .data1    (data1),
            .size0    (size0),
            .size1    (size1),
            .gnt0     (gnt0_o[g]),
            .gnt1     (gnt1_o[g]),
            .rdy0     (rdy0_o[g]),
            .rdy1     (rdy1_o[g]),
            .busy0    (busy0_o[g]),
            .busy1    (busy1_o[g]),
            .hash     (hash_o[g]),
            .tout     (tout_o[g]),
            .fe_cmd   (fe_cmd_o[g]),
            .fe_data  (fe_data_o[g]),
            .fe_size  (fe_size_o[g]),
            .fe_hash  (fe_hash),
            .fe_busy  (fe_busy),
            .fe_ready (fe_ready)
        );
    end

    // ---------------- session-level reference model ----------------
    int m_own   [2];     // -1: nobody owns the frontend
    bit m_drain [2];
    int m_dcnt  [2];
    bit m_pref  [2];     // port that wins a round-robin tie
    int m_idle  [2];
    bit m_blk   [2][2];

    function automatic int drain_min(int i);
        return i + 2;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i]    = -1;
            m_drain[i]  = 1'b0;
            m_dcnt[i]   = 0;
            m_pref[i]   = 1'b0;
            m_idle[i]   = 0;
            m_blk[i][0] = 1'b0;
            m_blk[i][1] = 1'b0;
        end
    endfunction

    function automatic void m_step();
        bit       r [2];
        bit [1:0] c [2];
        r[0] = req0;
        r[1] = req1;
        c[0] = cmd0;
        c[1] = cmd1;
        for (int i = 0; i < 2; i++) begin
            bit e0, e1, any;
            int w, o;
            e0  = r[0] && !m_blk[i][0];
            e1  = r[1] && !m_blk[i][1];
            any = e0 || e1;
            if (e0 && e1) w = (i == 1) ? 0 : int'(m_pref[i]);
            else          w = e1 ? 1 : 0;
            if (m_own[i] >= 0) begin
                o = m_own[i];
                if (!r[o]) begin
                    m_own[i] = -1; m_drain[i] = 1'b1; m_dcnt[i] = 0; m_idle[i] = 0;
                end else if (TOEN && c[o] == 2'b00 && !fe_busy) begin
                    if (m_idle[i] == TO - 1) begin
                        m_blk[i][o] = 1'b1;
                        m_own[i] = -1; m_drain[i] = 1'b1; m_dcnt[i] = 0; m_idle[i] = 0;
                    end else begin
                        m_idle[i]++;
                    end
                end else begin
                    m_idle[i] = 0;
                end
            end else if (m_drain[i]) begin
                if (m_dcnt[i] >= drain_min(i) - 1 && !fe_busy) begin
                    m_drain[i] = 1'b0;
                    if (any) begin
                        m_own[i] = w; m_idle[i] = 0; m_pref[i] = (w == 0);
                    end
                end else begin
                    m_dcnt[i]++;
                end
            end else if (any) begin
                m_own[i] = w; m_idle[i] = 0; m_pref[i] = (w == 0);
            end
            for (int p = 0; p < 2; p++) begin
                if (!r[p]) m_blk[i][p] = 1'b0;
            end
        end
    endfunction

    initial m_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit        g0, g1;
            bit [1:0]  ec;
            bit [15:0] ed;
            bit        es;
            g0 = (m_own[i] == 0);
            g1 = (m_own[i] == 1);
            ec = g0 ? cmd0  : (g1 ? cmd1  : 2'b00);
            ed = g0 ? data0 : (g1 ? data1 : 16'h0000);
            es = g0 ? size0 : (g1 ? size1 : 1'b0);
            chk("gnt0", i, 32'(gnt0_o[i]), 32'(g0));
            chk("gnt1", i, 32'(gnt1_o[i]), 32'(g1));
            chk("fe_cmd", i, 32'(fe_cmd_o[i]), 32'(ec));
            chk("fe_data", i, 32'(fe_data_o[i]), 32'(ed));
            chk("fe_size", i, 32'(fe_size_o[i]), 32'(es));
            chk("rdy0", i, 32'(rdy0_o[i]), 32'(g0 & fe_ready));
            chk("rdy1", i, 32'(rdy1_o[i]), 32'(g1 & fe_ready));
            chk("busy0", i, 32'(busy0_o[i]), 32'((req0 & !g0) | (g0 & fe_busy)));
            chk("busy1", i, 32'(busy1_o[i]), 32'((req1 & !g1) | (g1 & fe_busy)));
            chk("hash", i, 32'(hash_o[i]), 32'(fe_hash));
            chk("tout", i, 32'(tout_o[i]), 32'(m_blk[i][0] | m_blk[i][1]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus with hand-computed anchors ----------------
    initial begin
        req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; data0 = 0; data1 = 0;
        size0 = 0; size1 = 0; fe_hash = 16'h1234; fe_busy = 0; fe_ready = 1;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_gnt0", i, 32'(gnt0_o[i]), 0);
            chk("rst_gnt1", i, 32'(gnt1_o[i]), 0);
            chk("rst_fe_cmd", i, 32'(fe_cmd_o[i]), 0);
            chk("rst_tout", i, 32'(tout_o[i]), 0);
        end
        rst = 0;

        // single session from port 0
        req0 = 1; cmd0 = 2'b10; data0 = 16'h6162; size0 = 1;
        step();
        chk("s_gnt0", 0, 32'(gnt0_o[0]), 1);
        chk("s_fe_cmd", 0, 32'(fe_cmd_o[0]), 32'h2);
        chk("s_fe_data", 0, 32'(fe_data_o[0]), 32'h6162);
        chk("s_fe_size", 0, 32'(fe_size_o[0]), 1);
        chk("s_rdy1", 0, 32'(rdy1_o[0]), 0);
        chk("s_busy1", 0, 32'(busy1_o[0]), 0);

        // non-owner traffic is ignored, waiting port sees busy
        req1 = 1; cmd1 = 2'b01; data1 = 16'hBEEF;
        step();
        chk("no_fe_cmd", 0, 32'(fe_cmd_o[0]), 32'h2);
        chk("no_fe_data", 0, 32'(fe_data_o[0]), 32'h6162);
        chk("no_busy1", 0, 32'(busy1_o[0]), 1);
        chk("no_rdy1", 0, 32'(rdy1_o[0]), 0);

        // port 0 releases, re-requests during drain: RR hands to 1, fixed returns to 0
        req0 = 0;
        step();
        chk("d_gnt0", 0, 32'(gnt0_o[0]), 0);
        chk("d_gnt0", 1, 32'(gnt0_o[1]), 0);
        chk("d_fe_cmd", 0, 32'(fe_cmd_o[0]), 0);
        req0 = 1;
        step();
        chk("d2_gnt1", 0, 32'(gnt1_o[0]), 0);
        chk("d2_fe_cmd", 0, 32'(fe_cmd_o[0]), 0);
        step();
        chk("rr_gnt1", 0, 32'(gnt1_o[0]), 1);
        chk("rr_fe_cmd", 0, 32'(fe_cmd_o[0]), 32'h1);
        chk("fx_gnt0_wait", 1, 32'(gnt0_o[1]), 0);
        step();
        chk("fx_gnt0", 1, 32'(gnt0_o[1]), 1);
        chk("fx_fe_cmd", 1, 32'(fe_cmd_o[1]), 32'h2);

        // owner 1 releases while frontend busy: no handover until busy clears
        req1 = 0; fe_busy = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bh_gnt0", 0, 32'(gnt0_o[0]), 0);
            chk("bh_busy0", 0, 32'(busy0_o[0]), 1);
        end
        fe_busy = 0;
        step();
        chk("bh_gnt0_after", 0, 32'(gnt0_o[0]), 1);

        // asynchronous reset mid-session
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("ar_gnt0", 0, 32'(gnt0_o[0]), 0);
        chk("ar_fe_cmd", 0, 32'(fe_cmd_o[0]), 0);
        chk("ar_gnt0", 1, 32'(gnt0_o[1]), 0);
        req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0;
        step();
        rst = 0;
        step();
        chk("ar_idle_gnt0", 0, 32'(gnt0_o[0]), 0);
        chk("ar_idle_gnt1", 0, 32'(gnt1_o[0]), 0);

`ifdef SHA512_ARB_TIMEOUT_EN
        // idle owner is preempted after TO idle cycles and locked out until req drops
        req0 = 1; cmd0 = 2'b00;
        step();
        chk("to_gnt0", 0, 32'(gnt0_o[0]), 1);
        for (int k = 0; k < TO - 1; k++) begin
            step();
            chk("to_hold", 0, 32'(gnt0_o[0]), 1);
        end
        step();
        chk("to_drop", 0, 32'(gnt0_o[0]), 0);
        chk("to_tout", 0, 32'(tout_o[0]), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("to_locked", 0, 32'(gnt0_o[0]), 0);
        end
        req0 = 0;
        step();
        chk("to_clear", 0, 32'(tout_o[0]), 0);
        req0 = 1;
        step();
        chk("to_regrant", 0, 32'(gnt0_o[0]), 1);
        req0 = 0;
        step();
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) req0 = ~req0;
            if ($urandom_range(0, 15) == 0) req1 = ~req1;
            cmd0  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(0, 3)) : 2'b00;
            cmd1  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(0, 3)) : 2'b00;
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            size0 = 1'($urandom);
            size1 = 1'($urandom);
            if ($urandom_range(0, 7) == 0) fe_busy = ~fe_busy;
            fe_ready = 1'($urandom);
            fe_hash  = 16'($urandom);
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/omsp_sha512_arbiter.md
Name: omsp_sha512_arbiter

Overview:
- Shares one omsp_sha512_frontend instance between two requesters, e.g. port 0 for crypto-unit key derivation and port 1 for the software hash instruction.
- Grants whole hashing sessions, not individual words.
- Muxes the owner's cmd/data/size onto the frontend and gates ready/busy back to that owner only.
- Between sessions, inserts a drain phase so the frontend goes idle and sees cmd=00 before the next first write.

Parameters:
- PRIO_FIXED, 0: 0 = round-robin between ports; 1 = port 0 wins every tie.
- DRAIN_MIN, 2: minimum cycles with fe_cmd=00 between two sessions (range 1..15).
- TIMEOUT, 1024: owner-idle cycles before preemption; used only with the optional feature (range 2..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0 / req1  in  1  session request; held high for the whole session
- cmd0 / cmd1  in  2  requester command; bit0 read, bit1 write
- data0 / data1  in  16  requester write data
- size0 / size1  in  1  1 = 16-bit word, 0 = byte in data[7:0]
- gnt0 / gnt1  out  1  registered grant
- rdy0 / rdy1  out  1  fe_ready gated with own grant
- busy0 / busy1  out  1  requester-view busy
- hash  out  16  fe_hash broadcast; valid only to the granted requester
- tout  out  1  preemption flag for the optional feature; 0 without it
- fe_cmd  out  2  to frontend cmd_in
- fe_data  out  16  to frontend data
- fe_size  out  1  to frontend data_size
- fe_hash  in  16  from frontend hash
- fe_busy  in  1  from frontend busy
- fe_ready  in  1  from frontend ready_for_data

Behaviour:
- Reset values (async): state IDLE; gnt0=gnt1=0; tout=0; round-robin pointer favours port 0; drain counter 0.
- State machine:
  - IDLE: if any request, go to OWN0 or OWN1; the grant is registered, so gnt rises 1 cycle after req is sampled high.
  - OWN0 / OWN1: stay while the owner's req=1. When the owner's req=0 is sampled, go to DRAIN; gnt falls on that same edge.
  - DRAIN: counter increments each cycle. Leave when counter >= DRAIN_MIN-1 and fe_busy=0. Go directly to OWNx if a request is pending, otherwise to IDLE.
- Arbitration:
  - Evaluated only in IDLE and on DRAIN exit.
  - Round-robin: on a tie, the port not granted last wins; the pointer updates on every grant.
  - PRIO_FIXED=1: port 0 always wins a tie.
  - A port never gets two consecutive sessions while the other port is waiting (round-robin mode).
- Muxing (combinational from the registered state):
  - In OWNx: fe_cmd=cmdx, fe_data=datax, fe_size=sizex.
  - Otherwise: fe_cmd=00, fe_data=0, fe_size=0.
  - Non-owner cmd/data are ignored entirely.
- Handshake outputs:
  - rdyx = gntx & fe_ready.
  - busyx = (reqx & ~gntx) | (gntx & fe_busy). A waiting requester sees busy, so it never writes before its grant.
- Every new session starts with fe_cmd having been 00 for at least DRAIN_MIN cycles. This guarantees the frontend detects a fresh first write and restarts the digest.
- Boundary conditions:
  - Owner drops req while fe_busy=1: DRAIN holds until fe_busy=0, then arbitrates.
  - Both reqs rise in the same cycle: tie rule applies.
  - req glitch of 1 cycle in IDLE: a grant is still issued; the session ends at the next sampled req=0.
  - Non-owner req rising during OWN is held pending; there is no preemption except via the optional feature.
  - rst mid-session: immediately IDLE, gnt=0, fe_cmd=00; the frontend is reset by the same rst.

Optional Feature:
- Macro: SHA512_ARB_TIMEOUT_EN.
- Enabled:
  - In OWNx, a 16-bit counter increments on each cycle with cmdx=00 and fe_busy=0; it clears on any nonzero cmdx or fe_busy=1.
  - When the counter reaches TIMEOUT-1: gnt drops, state goes to DRAIN, and tout is set sticky for that port.
  - The preempted port is not granted again until its req has been sampled low for at least 1 cycle. That sampled-low cycle also clears tout.
- Disabled: no counter, tout tied 0, and the owner keeps the frontend for as long as its req is high.

Test Plan:
- Single session: req0=1 at cycle 0 -> gnt0=1 at cycle 1. cmd0=10 with data0=16'h6162, size0=1 appears on fe_cmd/fe_data in the same cycle. rdy1=busy1=0.
- Simultaneous req0=req1=1 from reset, round-robin -> gnt0 first. After req0 drops: fe_cmd=00 for ≥2 cycles, then gnt1=1. With PRIO_FIXED=1 and req0 re-raised during the drain, gnt0 wins instead.
- Owner releases with fe_busy=1 held for 20 cycles -> no grant until 1 cycle after fe_busy=0. busy1 stays 1 throughout.
- Non-owner drives cmd1=10 while port 0 owns -> fe_cmd tracks cmd0 only; rdy1=0.
- rst asserted mid-session with fe_cmd=10 -> gnt0=0, fe_cmd=00 asynchronously; after release, the state is IDLE.
- Macro on, TIMEOUT=8, owner idle -> gnt0 falls after 8 idle cycles, tout=1. gnt0 is not re-granted while req0 stays high; after req0 is sampled low, tout=0 and a new request is granted.
